// File: rtl/clock_pkg.sv
// Shared types, field moduli and BCD helpers for the digital clock datapath.
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int MOD_HOUR   = 24;
  localparam int MOD_MIN    = 60;
  localparam int MOD_SEC    = 60;
  localparam int MAX_DIGITS = 8;

  // Decode the low 'digits' BCD digits of a packed bus into binary.
  function automatic logic [31:0] bcd_to_bin(input logic [31:0] bcd, input int digits);
    logic [31:0] acc;
    bcd_digit_t  d;
    acc = '0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < digits) begin
        d   = bcd[4*i +: 4];
        acc = acc * 32'd10 + {28'd0, d};
      end
    end
    return acc;
  endfunction

  // True when every one of the low 'digits' nibbles is a legal decimal digit.
  function automatic logic bcd_valid(input logic [31:0] bcd, input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && bcd[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Combinational binary to packed-BCD converter (shift-and-add-3).
// The caller guarantees the binary input is below 10^DIGITS.
module bin2bcd #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 5
) (
  input  logic [BIN_W-1:0]    bin,
  output logic [4*DIGITS-1:0] bcd
);

  // Double-dabble: correct each digit >= 5 before shifting in the next bit.
  always_comb begin
    bcd = '0;
    for (int i = BIN_W - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[4*DIGITS-2:0], bin[i]};
    end
  end

endmodule

// File: rtl/counter_bcd_mod.sv
// BCD modulo counter for one time field (hours, minutes or seconds).
// Counts carry pulses up or down, accepts validated presets, emits a
// chaining carry/borrow, and renders a 12/24-hour display for hour fields.
module counter_bcd_mod
  import clock_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 24,
  parameter int CW      = $clog2(MODULUS)
) (
  input  logic                clk,
  input  logic                CR,
  input  logic                cin,
  input  logic                up_dn,
  input  logic                PE,
  input  logic [4*DIGITS-1:0] pre_val,
  input  logic                mode12,
  output logic [4*DIGITS-1:0] show_val,
  output logic                cout,
  output logic                pm,
  output logic                pre_err
);

  // Display path is at least 4 bits wide so the constant 12 always fits.
  localparam int            BW      = (CW < 4) ? 4 : CW;
  localparam int            SW      = 4 * DIGITS;
  localparam bit            IS_HOUR = (MODULUS == MOD_HOUR);
  localparam logic [CW-1:0] CNT_MAX = CW'(MODULUS - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          cout_nxt;
  logic          err_nxt;
  logic          pm_nxt;
  logic [31:0]   pre_dec;
  logic          pre_ok;
  logic [BW-1:0] cnt_ext;
  logic [BW-1:0] disp_bin;
  logic [SW-1:0] disp_bcd;

  assign pre_dec = bcd_to_bin(32'(pre_val), DIGITS);
  assign pre_ok  = bcd_valid(32'(pre_val), DIGITS) && (pre_dec < 32'(MODULUS));

  // Next count: preset beats counting; a carry arriving with a preset is dropped.
  always_comb begin
    cnt_nxt  = cnt;
    cout_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (PE) begin
      if (pre_ok) cnt_nxt = CW'(pre_dec);
      else        err_nxt = 1'b1;
    end else if (cin) begin
      if (up_dn) begin
        if (cnt == CNT_MAX) begin
          cnt_nxt  = '0;
          cout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end else begin
        if (cnt == '0) begin
          cnt_nxt  = CNT_MAX;
          cout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
    end
  end

  // Display value from the next count; 12h folding applies to hour fields only.
  always_comb begin
    cnt_ext  = BW'(cnt_nxt);
    disp_bin = cnt_ext;
    pm_nxt   = 1'b0;
    if (IS_HOUR) begin
      pm_nxt = (cnt_ext >= BW'(12));
      if (mode12) begin
        if (cnt_ext >= BW'(12)) disp_bin = cnt_ext - BW'(12);
        if (disp_bin == '0)     disp_bin = BW'(12);
      end
    end
  end

  bin2bcd #(
    .DIGITS (DIGITS),
    .BIN_W  (BW)
  ) u_bin2bcd (
    .bin (disp_bin),
    .bcd (disp_bcd)
  );

  // Count and output registers; clear overrides everything and emits no pulse.
  always_ff @(posedge clk) begin
    if (CR) begin
      cnt      <= '0;
      show_val <= '0;
      cout     <= 1'b0;
      pm       <= 1'b0;
      pre_err  <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      show_val <= disp_bcd;
      cout     <= cout_nxt;
      pm       <= pm_nxt;
      pre_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_counter_bcd_mod.sv
// Bench for counter_bcd_mod: an hour instance (MODULUS=24) and a minute
// instance (MODULUS=60) share stimulus and are checked every cycle against an
// integer reference model, plus directed checks against fixed constants.
module tb_counter_bcd_mod;

  logic       clk = 1'b0;
  logic       cr, cin, up_dn, pe, mode12;
  logic [7:0] pre_val;
  logic [7:0] show_a, show_b;
  logic       cout_a, cout_b, pm_a, pm_b, err_a, err_b;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state, index 0 = hours, 1 = minutes.
  int m_cnt  [2];
  int m_show [2];
  int m_cout [2];
  int m_pm   [2];
  int m_err  [2];

  always #5 clk = ~clk;

  counter_bcd_mod #(.DIGITS(2), .MODULUS(24)) dut_a (
    .clk(clk), .CR(cr), .cin(cin), .up_dn(up_dn), .PE(pe), .pre_val(pre_val),
    .mode12(mode12), .show_val(show_a), .cout(cout_a), .pm(pm_a), .pre_err(err_a)
  );

  counter_bcd_mod #(.DIGITS(2), .MODULUS(60)) dut_b (
    .clk(clk), .CR(cr), .cin(cin), .up_dn(up_dn), .PE(pe), .pre_val(pre_val),
    .mode12(mode12), .show_val(show_b), .cout(cout_b), .pm(pm_b), .pre_err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic int mod_of(input int idx);
    return (idx == 0) ? 24 : 60;
  endfunction

  function automatic int to_bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  function automatic int disp(input int c, input int modv, input bit m12);
    int h;
    if (modv == 24 && m12) begin
      h = c % 12;
      if (h == 0) h = 12;
      return to_bcd(h);
    end
    return to_bcd(c);
  endfunction

  task automatic model_step();
    int modv, hi, lo;
    for (int idx = 0; idx < 2; idx++) begin
      modv = mod_of(idx);
      m_cout[idx] = 0;
      m_err[idx]  = 0;
      if (cr) begin
        m_cnt[idx]  = 0;
        m_show[idx] = 0;
        m_pm[idx]   = 0;
      end else begin
        if (pe) begin
          hi = int'(pre_val[7:4]);
          lo = int'(pre_val[3:0]);
          if (hi <= 9 && lo <= 9 && hi * 10 + lo < modv) m_cnt[idx] = hi * 10 + lo;
          else m_err[idx] = 1;
        end else if (cin) begin
          if (up_dn) begin
            m_cnt[idx]  = (m_cnt[idx] + 1) % modv;
            m_cout[idx] = (m_cnt[idx] == 0) ? 1 : 0;
          end else begin
            m_cout[idx] = (m_cnt[idx] == 0) ? 1 : 0;
            m_cnt[idx]  = (m_cnt[idx] + modv - 1) % modv;
          end
        end
        m_show[idx] = disp(m_cnt[idx], modv, mode12);
        m_pm[idx]   = (modv == 24 && m_cnt[idx] >= 12) ? 1 : 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_show_a", 32'(show_a), m_show[0]);
    chk("model_cout_a", 32'(cout_a), m_cout[0]);
    chk("model_pm_a",   32'(pm_a),   m_pm[0]);
    chk("model_err_a",  32'(err_a),  m_err[0]);
    chk("model_show_b", 32'(show_b), m_show[1]);
    chk("model_cout_b", 32'(cout_b), m_cout[1]);
    chk("model_pm_b",   32'(pm_b),   m_pm[1]);
    chk("model_err_b",  32'(err_b),  m_err[1]);
  endtask

  initial begin
    int couts;
    int v;
    cr = 1'b1; pe = 1'b0; cin = 1'b0; up_dn = 1'b1; mode12 = 1'b0; pre_val = 8'h00;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_show[i] = 0; m_cout[i] = 0; m_pm[i] = 0; m_err[i] = 0;
    end

    // Reset, 24h then 12h
    tick(); tick();
    chk("rst_show", 32'(show_a), 32'h00);
    chk("rst_cout", 32'(cout_a), 0);
    chk("rst_pm",   32'(pm_a),   0);
    mode12 = 1'b1;
    tick();
    cr = 1'b0;
    tick();
    chk("rst12_show", 32'(show_a), 32'h12);
    chk("rst12_pm",   32'(pm_a),   0);

    // Up wrap and down wrap
    mode12 = 1'b0; pe = 1'b1; pre_val = 8'h23;
    tick();
    pe = 1'b0;
    chk("pre23_show", 32'(show_a), 32'h23);
    cin = 1'b1; up_dn = 1'b1;
    tick();
    cin = 1'b0;
    chk("upwrap_show", 32'(show_a), 32'h00);
    chk("upwrap_cout", 32'(cout_a), 1);
    tick();
    chk("upwrap_cout_once", 32'(cout_a), 0);
    cin = 1'b1; up_dn = 1'b0;
    tick();
    cin = 1'b0;
    chk("dnwrap_show", 32'(show_a), 32'h23);
    chk("dnwrap_cout", 32'(cout_a), 1);
    tick();
    chk("dnwrap_cout_once", 32'(cout_a), 0);

    // Preset validation
    pe = 1'b1; pre_val = 8'h24;
    tick();
    chk("pre24_err",  32'(err_a),  1);
    chk("pre24_show", 32'(show_a), 32'h23);
    pe = 1'b0;
    tick();
    chk("pre24_err_once", 32'(err_a), 0);
    pe = 1'b1; pre_val = 8'h1A;
    tick();
    chk("pre1a_err", 32'(err_a), 1);
    pre_val = 8'h09;
    tick();
    chk("pre09_err",  32'(err_a),  0);
    chk("pre09_show", 32'(show_a), 32'h09);

    // 12h rendering
    mode12 = 1'b1; pre_val = 8'h13;
    tick();
    chk("h13_show", 32'(show_a), 32'h01);
    chk("h13_pm",   32'(pm_a),   1);
    pre_val = 8'h00;
    tick();
    chk("h00_show", 32'(show_a), 32'h12);
    chk("h00_pm",   32'(pm_a),   0);
    pe = 1'b0; mode12 = 1'b0;
    tick();
    chk("mode24_rerender", 32'(show_a), 32'h00);

    // Full modulo-60 lap with 12h mode requested (ignored by the minute field)
    mode12 = 1'b1; pe = 1'b1; pre_val = 8'h00;
    tick();
    pe = 1'b0; cin = 1'b1; up_dn = 1'b1; couts = 0;
    repeat (60) begin
      tick();
      couts += int'(cout_b);
    end
    cin = 1'b0;
    chk("lap60_show",  32'(show_b), 32'h00);
    chk("lap60_couts", couts, 1);
    chk("lap60_pm",    32'(pm_b), 0);

    // Priority: PE over cin, CR over PE
    mode12 = 1'b0; pe = 1'b1; cin = 1'b1; pre_val = 8'h05;
    tick();
    chk("pe_cin_show_a", 32'(show_a), 32'h05);
    chk("pe_cin_show_b", 32'(show_b), 32'h05);
    cin = 1'b0; cr = 1'b1; pre_val = 8'h07;
    tick();
    chk("cr_pe_show", 32'(show_a), 32'h00);
    cr = 1'b0; pe = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cr    = ($urandom_range(0, 49) == 0);
      pe    = ($urandom_range(0, 7) == 0);
      cin   = $urandom_range(0, 1) != 0;
      up_dn = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 19) == 0) mode12 = ~mode12;
      if ($urandom_range(0, 1) != 0) begin
        pre_val = 8'($urandom);
      end else begin
        v = int'($urandom_range(0, 59));
        pre_val = 8'(to_bcd(v));
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
